amo_arbiter: RTL and testbench

AMO_ARBITER -- requirements
Module: amo_arbiter

---
 rtl/ariane_pkg.sv | 34 +++
 rtl/amo_rr_picker.sv | 29 ++
 rtl/amo_arbiter.sv | 95 +++++++++
 tb/tb_amo_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// AMO request/response types shared between the cores and the cache subsystem.
package ariane_pkg;

  typedef enum logic [3:0] {
    AMO_NONE = 4'b0000,
    AMO_LR   = 4'b0001,
    AMO_SC   = 4'b0010,
    AMO_SWAP = 4'b0011,
    AMO_ADD  = 4'b0100,
    AMO_AND  = 4'b0101,
    AMO_OR   = 4'b0110,
    AMO_XOR  = 4'b0111,
    AMO_MAX  = 4'b1000,
    AMO_MAXU = 4'b1001,
    AMO_MIN  = 4'b1010,
    AMO_MINU = 4'b1011,
    AMO_CAS1 = 4'b1100,
    AMO_CAS2 = 4'b1101
  } amo_t;

  typedef struct packed {
    logic        req;
    amo_t        amo_op;
    logic [1:0]  size;
    logic [63:0] operand_a;
    logic [63:0] operand_b;
  } amo_req_t;

  typedef struct packed {
    logic        ack;
    logic [63:0] result;
  } amo_resp_t;

endpackage

// File: rtl/amo_rr_picker.sv
// Combinational round-robin search: first requesting port at or after rr_ptr_i, wrapping.
module amo_rr_picker #(
  parameter int unsigned NR_PORTS = 2
) (
  input  logic [NR_PORTS-1:0]         req_i,
  input  logic [$clog2(NR_PORTS)-1:0] rr_ptr_i,
  output logic                        valid_o,
  output logic [$clog2(NR_PORTS)-1:0] idx_o
);

  localparam int unsigned IDX_W = $clog2(NR_PORTS);

  int unsigned cand;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
      cand = 32'(rr_ptr_i) + i;
      if (cand >= NR_PORTS) cand = cand - NR_PORTS;
      if (!valid_o && req_i[IDX_W'(cand)]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/amo_arbiter.sv
// Serialises AMO requests from NR_PORTS requesters onto one cache port, round-robin.
module amo_arbiter
  import ariane_pkg::*;
#(
  parameter int unsigned NR_PORTS = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  amo_req_t  [NR_PORTS-1:0]      amo_req_i,
  output amo_resp_t [NR_PORTS-1:0]      amo_resp_o,
  output amo_req_t                      amo_req_o,
  input  amo_resp_t                     amo_resp_i,
  output logic                          busy_o,
  output logic [$clog2(NR_PORTS)-1:0]   gnt_idx_o
);

  localparam int unsigned IDX_W = $clog2(NR_PORTS);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     gnt_idx_q, gnt_idx_d;
  amo_req_t             payload_q, payload_d;

  logic [NR_PORTS-1:0]  req_vec;
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;

  always_comb begin
    req_vec = '0;
    for (int unsigned k = 0; k < NR_PORTS; k++) req_vec[k] = amo_req_i[k].req;
  end

  amo_rr_picker #(.NR_PORTS(NR_PORTS)) u_picker (
    .req_i    (req_vec),
    .rr_ptr_i (rr_ptr_q),
    .valid_o  (pick_valid),
    .idx_o    (pick_idx)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
      payload_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_idx_q <= gnt_idx_d;
      payload_q <= payload_d;
    end
  end

  // Next state: grant in IDLE, release on cache ack in BUSY; acks in IDLE are dropped.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_idx_d = gnt_idx_q;
    payload_d = payload_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d       = BUSY;
          gnt_idx_d     = pick_idx;
          payload_d     = amo_req_i[pick_idx];
          payload_d.req = 1'b0;
        end
      end
      BUSY: begin
        if (amo_resp_i.ack) begin
          state_d  = IDLE;
          rr_ptr_d = (gnt_idx_q == IDX_W'(NR_PORTS - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o    = (state_q == BUSY);
  assign gnt_idx_o = gnt_idx_q;

  always_comb begin
    amo_req_o     = payload_q;
    amo_req_o.req = (state_q == BUSY);
  end

  // Response is routed straight through to the granted port only.
  always_comb begin
    amo_resp_o = '0;
    if (state_q == BUSY) amo_resp_o[gnt_idx_q] = amo_resp_i;
  end

endmodule

// File: tb/tb_amo_arbiter.sv
// Scoreboard bench for amo_arbiter with a 2-port and a 4-port instance.
module tb_amo_arbiter;
  import ariane_pkg::*;

  typedef struct packed {
    logic [2:0]  idx;
    amo_t        op;
    logic [63:0] a;
    logic [63:0] b;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst2_n, rst4_n;
  amo_req_t  [1:0] req2;
  amo_resp_t [1:0] resp2o;
  amo_req_t        reqo2;
  amo_resp_t       respi2;
  logic            busy2;
  logic [0:0]      gnt2;

  amo_req_t  [3:0] req4;
  amo_resp_t [3:0] resp4o;
  amo_req_t        reqo4;
  amo_resp_t       respi4;
  logic            busy4;
  logic [1:0]      gnt4;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  amo_arbiter #(.NR_PORTS(2)) dut2 (
    .clk_i(clk), .rst_ni(rst2_n), .amo_req_i(req2), .amo_resp_o(resp2o),
    .amo_req_o(reqo2), .amo_resp_i(respi2), .busy_o(busy2), .gnt_idx_o(gnt2)
  );

  amo_arbiter #(.NR_PORTS(4)) dut4 (
    .clk_i(clk), .rst_ni(rst4_n), .amo_req_i(req4), .amo_resp_o(resp4o),
    .amo_req_o(reqo4), .amo_resp_i(respi4), .busy_o(busy4), .gnt_idx_o(gnt4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] rr_model(input logic [7:0] reqv, input int ptr, input int n);
    for (int i = 0; i < n; i++) begin
      if (reqv[(ptr + i) % n]) return 3'((ptr + i) % n);
    end
    return 3'd0;
  endfunction

  task automatic reset2();
    req2 = '0; respi2 = '0; rst2_n = 1'b0;
    tick();
    rst2_n = 1'b1;
  endtask

  task automatic test_reset();
    req2 = '0; respi2 = '1; rst2_n = 1'b0;
    tick(); tick();
    vectors++; if (busy2 !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%0b want=0", busy2); end
    vectors++; if (reqo2.req !== 1'b0) begin miscompares++; $display("FAIL reset_req got=%0b want=0", reqo2.req); end
    vectors++; if (gnt2 !== 1'b0) begin miscompares++; $display("FAIL reset_gnt got=%0d want=0", gnt2); end
    vectors++; if (reqo2.operand_a !== 64'h0) begin miscompares++; $display("FAIL reset_payload got=%h want=0", reqo2.operand_a); end
    vectors++; if (resp2o[0].ack !== 1'b0 || resp2o[1].ack !== 1'b0) begin
      miscompares++; $display("FAIL reset_acks got=%b%b want=00", resp2o[1].ack, resp2o[0].ack); end
    respi2 = '0; rst2_n = 1'b1;
  endtask

  task automatic test_single();
    exp_t e;
    reset2();
    req2[1] = '{req: 1'b1, amo_op: AMO_ADD, size: 2'b11, operand_a: 64'h8000_0010, operand_b: 64'd5};
    sb.push_back('{idx: 3'd1, op: AMO_ADD, a: 64'h8000_0010, b: 64'd5});
    tick();
    req2[1].req = 1'b0;
    e = sb.pop_front();
    vectors++; if (reqo2.req !== 1'b1) begin miscompares++; $display("FAIL single_req_latency got=%0b want=1", reqo2.req); end
    vectors++; if (gnt2 !== e.idx[0:0]) begin miscompares++; $display("FAIL single_gnt got=%0d want=%0d", gnt2, e.idx); end
    vectors++; if (reqo2.amo_op !== e.op || reqo2.size !== 2'b11 || reqo2.operand_a !== e.a || reqo2.operand_b !== e.b) begin
      miscompares++; $display("FAIL single_payload got=%0d/%h/%h want=%0d/%h/%h", reqo2.amo_op, reqo2.operand_a, reqo2.operand_b, e.op, e.a, e.b); end
    respi2 = '{ack: 1'b1, result: 64'd7};
    #1;
    vectors++; if (resp2o[1].ack !== 1'b1 || resp2o[1].result !== 64'd7) begin
      miscompares++; $display("FAIL single_resp got=%0b/%0d want=1/7", resp2o[1].ack, resp2o[1].result); end
    vectors++; if (resp2o[0].ack !== 1'b0 || resp2o[0].result !== 64'd0) begin
      miscompares++; $display("FAIL single_other_port got=%0b/%0d want=0/0", resp2o[0].ack, resp2o[0].result); end
    tick();
    respi2 = '0;
    vectors++; if (busy2 !== 1'b0 || reqo2.req !== 1'b0) begin
      miscompares++; $display("FAIL single_release got busy=%0b req=%0b want 0/0", busy2, reqo2.req); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   ptr, c;
    reset2();
    for (int k = 0; k < 2; k++)
      req2[k] = '{req: 1'b1, amo_op: AMO_OR, size: 2'b10, operand_a: 64'h1000 + 64'(k), operand_b: 64'h20 + 64'(k)};
    ptr = 0;
    sb.push_back('{idx: rr_model(8'h03, ptr, 2), op: AMO_OR, a: 64'h1000 + 64'(rr_model(8'h03, ptr, 2)), b: 64'h20 + 64'(rr_model(8'h03, ptr, 2))});
    c = 0;
    for (int g = 0; g < 4; g++) begin
      while (reqo2.req !== 1'b1 && c < 10) begin tick(); c++; end
      vectors++; if (reqo2.req !== 1'b1) begin miscompares++; $display("FAIL b2b_timeout grant=%0d got req=0 want 1", g); end
      vectors++; if (c !== ((g == 0) ? 1 : 2)) begin miscompares++; $display("FAIL b2b_latency grant=%0d got=%0d want=%0d", g, c, (g == 0) ? 1 : 2); end
      e = sb.pop_front();
      vectors++; if (gnt2 !== e.idx[0:0] || reqo2.operand_a !== e.a || reqo2.operand_b !== e.b) begin
        miscompares++; $display("FAIL b2b_grant grant=%0d got=%0d/%h want=%0d/%h", g, gnt2, reqo2.operand_a, e.idx, e.a); end
      respi2 = '{ack: 1'b1, result: 64'(g + 100)};
      #1;
      vectors++; if (resp2o[e.idx[0]].ack !== 1'b1 || resp2o[e.idx[0]].result !== 64'(g + 100) || resp2o[~e.idx[0]].ack !== 1'b0) begin
        miscompares++; $display("FAIL b2b_resp grant=%0d got ack=%b%b want port %0d only", g, resp2o[1].ack, resp2o[0].ack, e.idx); end
      ptr = (int'(e.idx) + 1) % 2;
      sb.push_back('{idx: rr_model(8'h03, ptr, 2), op: AMO_OR, a: 64'h1000 + 64'(rr_model(8'h03, ptr, 2)), b: 64'h20 + 64'(rr_model(8'h03, ptr, 2))});
      tick();
      respi2 = '0;
      c = 1;
    end
    sb.delete();
    req2 = '0;
  endtask

  task automatic test_stability();
    reset2();
    req2[0] = '{req: 1'b1, amo_op: AMO_SWAP, size: 2'b11, operand_a: 64'h40, operand_b: 64'd1};
    tick();
    req2[0].operand_b = 64'd9;
    req2[0].req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (reqo2.req !== 1'b1 || reqo2.operand_b !== 64'd1 || reqo2.amo_op !== AMO_SWAP) begin
        miscompares++; $display("FAIL stable_payload cycle=%0d got req=%0b b=%0d want req=1 b=1", i, reqo2.req, reqo2.operand_b); end
    end
    respi2 = '{ack: 1'b1, result: 64'd3};
    tick();
    respi2 = '0;
    vectors++; if (busy2 !== 1'b0) begin miscompares++; $display("FAIL stable_release got busy=%0b want=0", busy2); end
  endtask

  task automatic test_spurious_ack();
    reset2();
    respi2 = '{ack: 1'b1, result: 64'hdead};
    #1;
    vectors++; if (resp2o[0].ack !== 1'b0 || resp2o[1].ack !== 1'b0 || resp2o[1].result !== 64'd0) begin
      miscompares++; $display("FAIL spurious_acks got=%b%b want=00", resp2o[1].ack, resp2o[0].ack); end
    tick(); tick();
    vectors++; if (busy2 !== 1'b0) begin miscompares++; $display("FAIL spurious_busy got=%0b want=0", busy2); end
    respi2 = '0;
    req2[0].req = 1'b1; req2[1].req = 1'b1;
    tick();
    vectors++; if (busy2 !== 1'b1 || gnt2 !== 1'b0) begin
      miscompares++; $display("FAIL spurious_next_grant got busy=%0b gnt=%0d want 1/0", busy2, gnt2); end
    req2 = '0;
    respi2.ack = 1'b1;
    tick();
    respi2 = '0;
  endtask

  task automatic test_reset_mid();
    reset2();
    req2[1] = '{req: 1'b1, amo_op: AMO_XOR, size: 2'b11, operand_a: 64'h77, operand_b: 64'h5};
    tick();
    req2 = '0;
    vectors++; if (busy2 !== 1'b1 || gnt2 !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_setup got busy=%0b gnt=%0d want 1/1", busy2, gnt2); end
    rst2_n = 1'b0;
    tick();
    rst2_n = 1'b1;
    vectors++; if (reqo2.req !== 1'b0 || busy2 !== 1'b0 || gnt2 !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_state got req=%0b busy=%0b gnt=%0d want 0/0/0", reqo2.req, busy2, gnt2); end
    respi2 = '{ack: 1'b1, result: 64'h1};
    #1;
    vectors++; if (resp2o[1].ack !== 1'b0 || resp2o[0].ack !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_stray_ack got=%b%b want=00", resp2o[1].ack, resp2o[0].ack); end
    tick();
    respi2 = '0;
    vectors++; if (busy2 !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got=%0b want=0", busy2); end
  endtask

  task automatic test_fairness();
    exp_t       e;
    logic [7:0] reqv;
    logic [2:0] obs [12];
    logic [3:0] mask;
    int         ptr, c;
    req4 = '0; respi4 = '0; rst4_n = 1'b0;
    tick();
    rst4_n = 1'b1;
    reqv = 8'h0f;
    for (int k = 0; k < 4; k++)
      req4[k] = '{req: reqv[k], amo_op: AMO_MAX, size: 2'b11, operand_a: 64'(k), operand_b: 64'h0};
    ptr = 0;
    sb.push_back('{idx: rr_model(reqv, ptr, 4), op: AMO_MAX, a: 64'(rr_model(reqv, ptr, 4)), b: 64'h0});
    for (int g = 0; g < 12; g++) begin
      c = 0;
      while (reqo4.req !== 1'b1 && c < 10) begin tick(); c++; end
      vectors++; if (reqo4.req !== 1'b1) begin miscompares++; $display("FAIL fair_timeout grant=%0d got req=0 want 1", g); end
      e = sb.pop_front();
      obs[g] = 3'(gnt4);
      vectors++; if (gnt4 !== e.idx[1:0] || reqo4.operand_a !== e.a) begin
        miscompares++; $display("FAIL fair_grant grant=%0d got=%0d want=%0d", g, gnt4, e.idx); end
      if (g >= 3 && g <= 7) begin
        mask = '0;
        for (int j = g - 3; j <= g; j++) mask[obs[j][1:0]] = 1'b1;
        vectors++; if (mask !== 4'hf) begin miscompares++; $display("FAIL fair_window end=%0d got mask=%h want=f", g, mask); end
      end
      if (g == 7) begin
        reqv = 8'h05;
        for (int k = 0; k < 4; k++) req4[k].req = reqv[k];
      end
      respi4 = '{ack: 1'b1, result: 64'(g)};
      ptr = (int'(e.idx) + 1) % 4;
      sb.push_back('{idx: rr_model(reqv, ptr, 4), op: AMO_MAX, a: 64'(rr_model(reqv, ptr, 4)), b: 64'h0});
      tick();
      respi4 = '0;
    end
    sb.delete();
    req4 = '0;
  endtask

  initial begin
    rst2_n = 1'b0; rst4_n = 1'b0;
    req2 = '0; req4 = '0; respi2 = '0; respi4 = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stability();
    test_spurious_ack();
    test_reset_mid();
    test_fairness();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
